// File: rtl/soc_reset_sequencer.sv
// Board reset sequencer: PLL reset and lock qualification with timeout/retry,
// button debounce, and a fixed SoC reset hold before release.
module soc_reset_sequencer #(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RESET_HOLD_CYCLES   = 256,
  parameter int DEBOUNCE_CYCLES     = 50000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       button_n,
  output logic       pll_reset,
  output logic       soc_reset,
  output logic       ready,
  output logic       lock_lost,
  output logic [2:0] state_dbg
);

  localparam int M0 = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                      PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int M1 = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                      LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
  localparam int M2 = (M0 > M1) ? M0 : M1;
  localparam int MAXP = (M2 > DEBOUNCE_CYCLES) ? M2 : DEBOUNCE_CYCLES;
  localparam int CW = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] PLL_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HLD_LAST = CW'(RESET_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_HOLD      = 3'd3,
    S_RUN       = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic [SYNC_STAGES-1:0] btn_sync_q;
  logic                   locked_s;
  logic                   button_s;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   db_cnt_q, db_cnt_d;
  logic            pressed_q, pressed_d;
  logic            press_evt;
  logic            restart;

  logic pll_reset_q, pll_reset_d;
  logic soc_reset_q, soc_reset_d;
  logic ready_q, ready_d;
  logic lock_lost_q, lock_lost_d;

  assign locked_s = lock_sync_q[SYNC_STAGES-1];
  assign button_s = btn_sync_q[SYNC_STAGES-1];

  always_comb begin
    db_cnt_d  = db_cnt_q;
    pressed_d = pressed_q;
    press_evt = 1'b0;
    if (button_s) begin
      db_cnt_d  = '0;
      pressed_d = 1'b0;
    end else if (!pressed_q) begin
      if (db_cnt_q == DB_LAST) begin
        pressed_d = 1'b1;
        press_evt = 1'b1;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Priority inside each state: lock loss, then button, then expiry.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    lock_lost_d = lock_lost_q;
    restart     = 1'b0;
    case (state_q)
      S_PLL_RST: begin
        if (cnt_q == PLL_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (locked_s) state_d = S_STABLE;
        else if (cnt_q == TO_LAST) state_d = S_PLL_RST;
      end
      S_STABLE: begin
        if (!locked_s) state_d = S_WAIT_LOCK;
        else if (press_evt) state_d = S_HOLD;
        else if (cnt_q == STB_LAST) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!locked_s) state_d = S_WAIT_LOCK;
        else if (press_evt || pressed_q) restart = 1'b1;
        else if (cnt_q == HLD_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        restart = 1'b1;
        if (!locked_s) begin
          lock_lost_d = 1'b1;
          state_d     = S_WAIT_LOCK;
        end else if (press_evt) begin
          state_d = S_HOLD;
        end
      end
      default: state_d = S_PLL_RST;
    endcase
    if (restart || (state_d != state_q)) cnt_d = '0;
    pll_reset_d = (state_d == S_PLL_RST);
    soc_reset_d = (state_d != S_RUN);
    ready_d     = (state_d == S_RUN);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      lock_sync_q <= '0;
      btn_sync_q  <= '1;
      state_q     <= S_PLL_RST;
      cnt_q       <= '0;
      db_cnt_q    <= '0;
      pressed_q   <= 1'b0;
      pll_reset_q <= 1'b1;
      soc_reset_q <= 1'b1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
    end else begin
      lock_sync_q[0] <= pll_locked;
      btn_sync_q[0]  <= button_n;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        lock_sync_q[i] <= lock_sync_q[i-1];
        btn_sync_q[i]  <= btn_sync_q[i-1];
      end
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      db_cnt_q    <= db_cnt_d;
      pressed_q   <= pressed_d;
      pll_reset_q <= pll_reset_d;
      soc_reset_q <= soc_reset_d;
      ready_q     <= ready_d;
      lock_lost_q <= lock_lost_d;
    end
  end

  assign pll_reset = pll_reset_q;
  assign soc_reset = soc_reset_q;
  assign ready     = ready_q;
  assign lock_lost = lock_lost_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_soc_reset_sequencer.sv
// Directed bench for soc_reset_sequencer with small timing parameters
// (SYNC=2, PLL_RST=4, TIMEOUT=32, STABLE=8, HOLD=6, DEBOUNCE=4).
module tb_soc_reset_sequencer;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       pll_locked;
  logic       button_n;
  logic       pll_reset;
  logic       soc_reset;
  logic       ready;
  logic       lock_lost;
  logic [2:0] state_dbg;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  soc_reset_sequencer #(
    .SYNC_STAGES        (2),
    .PLL_RST_CYCLES     (4),
    .LOCK_TIMEOUT_CYCLES(32),
    .LOCK_STABLE_CYCLES (8),
    .RESET_HOLD_CYCLES  (6),
    .DEBOUNCE_CYCLES    (4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .pll_locked(pll_locked),
    .button_n  (button_n),
    .pll_reset (pll_reset),
    .soc_reset (soc_reset),
    .ready     (ready),
    .lock_lost (lock_lost),
    .state_dbg (state_dbg)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // {pll_reset, soc_reset, ready, lock_lost, 0, state_dbg}
  function automatic int outs();
    return int'({pll_reset, soc_reset, ready, lock_lost, 1'b0, state_dbg});
  endfunction

  localparam int RST_OUTS = 'hC0;

  initial begin
    reset_n    = 1'b0;
    pll_locked = 1'b1;
    button_n   = 1'b1;
    repeat (3) step();
    chk("rst_outs", outs(), RST_OUTS);

    // Release with lock already high: RUN 19 edges later.
    reset_n = 1'b1;
    for (int k = 1; k <= 19; k++) begin
      step();
      chk($sformatf("rel_pll_k%0d", k), int'(pll_reset), int'(k < 4));
      chk($sformatf("rel_soc_k%0d", k), int'(soc_reset), int'(k < 19));
      chk($sformatf("rel_st_k%0d", k), int'(state_dbg),
          (k < 4) ? 0 : (k < 5) ? 1 : (k < 13) ? 2 : (k < 19) ? 3 : 4);
    end
    chk("rel_ready", int'(ready), 1);

    // Lock loss in RUN.
    pll_locked = 1'b0;
    step();
    chk("loss_e1_soc", int'(soc_reset), 0);
    step();
    chk("loss_e2_soc", int'(soc_reset), 0);
    step();
    chk("loss_e3_soc", int'(soc_reset), 1);
    chk("loss_e3_st", int'(state_dbg), 1);
    chk("loss_e3_flag", int'(lock_lost), 1);
    pll_locked = 1'b1;
    for (int j = 1; j <= 17; j++) begin
      step();
      chk($sformatf("relock_rdy_j%0d", j), int'(ready), int'(j == 17));
      chk($sformatf("relock_pll_j%0d", j), int'(pll_reset), 0);
    end
    chk("relock_flag", int'(lock_lost), 1);

    // One-cycle reset pulse in RUN with lock_lost set.
    reset_n = 1'b0;
    step();
    chk("midrst_outs", outs(), RST_OUTS);
    reset_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      chk($sformatf("rst2_pll_k%0d", k), int'(pll_reset), int'(k < 4));
      chk($sformatf("rst2_st_k%0d", k), int'(state_dbg),
          (k < 4) ? 0 : (k < 5) ? 1 : 2);
    end

    // Three-cycle lock glitch in STABLE.
    pll_locked = 1'b0;
    step();
    chk("gl_e8_st", int'(state_dbg), 2);
    step();
    chk("gl_e9_st", int'(state_dbg), 2);
    step();
    chk("gl_e10_st", int'(state_dbg), 1);
    pll_locked = 1'b1;
    step();
    chk("gl_e11_st", int'(state_dbg), 1);
    step();
    chk("gl_e12_st", int'(state_dbg), 1);
    step();
    chk("gl_e13_st", int'(state_dbg), 2);
    for (int j = 1; j <= 14; j++) begin
      step();
      chk($sformatf("gl_soc_j%0d", j), int'(soc_reset), int'(j < 14));
      chk($sformatf("gl_pll_j%0d", j), int'(pll_reset), 0);
    end
    chk("gl_flag", int'(lock_lost), 0);

    // Short press is filtered out.
    button_n = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      step();
      if (j == 3) button_n = 1'b1;
      chk($sformatf("short_st_j%0d", j), int'(state_dbg), 4);
    end

    // Long press: HOLD while held, RUN after the hold count.
    button_n = 1'b0;
    for (int k = 1; k <= 29; k++) begin
      step();
      if (k == 20) button_n = 1'b1;
      chk($sformatf("btn_st_k%0d", k), int'(state_dbg),
          (k <= 5) ? 4 : (k <= 28) ? 3 : 4);
      chk($sformatf("btn_pll_k%0d", k), int'(pll_reset), 0);
    end
    chk("btn_ready", int'(ready), 1);

    // Lock never asserted: retry forever.
    pll_locked = 1'b0;
    reset_n    = 1'b0;
    step();
    chk("nolock_rst", outs(), RST_OUTS);
    reset_n = 1'b1;
    for (int k = 1; k <= 180; k++) begin
      step();
      chk($sformatf("nolock_pll_k%0d", k), int'(pll_reset),
          int'((k % 36) < 4));
      chk($sformatf("nolock_sr_k%0d", k), int'({soc_reset, ready}), 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
